trng_pool: RTL and testbench
============================

TRNG_POOL -- requirements
Module: trng_pool

Interface
REQ-001 SHALL have parameter W, default 32, output word width in bits.
REQ-002 SHALL have parameter RI, default 8, number of entropy lanes; W % RI == 0 and 1 <= RI <= W.
REQ-003 SHALL have parameter O, default 3, per-lane parity filter order; O == 1 is a pass-through.
REQ-004 SHALL have parameter DEPTH, default 4, output FIFO depth in words; a power of two, at least 2.
REQ-005 SHALL have parameter RCT_C, default 16, repetition-count cutoff; 2 <= RCT_C <= 255.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 es_gen  out  1  enables the external entropy sources.
REQ-010 es_rnb  in  RI  raw random bit per lane.
REQ-011 es_val  in  RI  per-lane qualifier for es_rnb.
REQ-012 rdn_vld  out  1  FIFO head word valid.
REQ-013 rdn_rdy  in  1  consumer accepts the head word.
REQ-014 rdn  out  W  FIFO head word.
REQ-015 lvl  out  clog2(DEPTH)+1  FIFO occupancy.
REQ-016 alarm  out  1  health-test failure, sticky.
REQ-017 alarm_clr  in  1  clears alarm.

Function
REQ-018 Per-lane filter SHALL shift in es_rnb[i] when es_val[i]=1 and, on every O-th accepted bit, emit a one-cycle valid carrying the XOR of the last O bits, registered one cycle after the O-th bit.
REQ-019 Collector SHALL latch each lane's filtered bit and set a per-lane flag; when all RI flags are set, it SHALL append the RI-bit slice and clear all flags in the same cycle. A lane valid arriving in that cycle SHALL be kept and its flag set.
REQ-020 Slice 0 SHALL end up in rdn[W-1:W-RI], with later slices shifted in below it, lane i at the LSB-relative position i within each slice.
REQ-021 After W/RI slices, the assembled word SHALL be pushed into the FIFO on the next cycle; the slice counter SHALL wrap to 0.
REQ-022 FIFO SHALL be first-word-fall-through: rdn_vld = (lvl != 0) and rdn = the head word. A pop happens when rdn_vld & rdn_rdy.
REQ-023 Simultaneous push and pop SHALL leave lvl unchanged; a push when lvl == DEPTH SHALL NOT occur (see REQ-025).
REQ-024 Control FSM states: IDLE, FILL, FULL, ALARM.
  - IDLE->FILL the cycle after reset deasserts.
  - FILL->FULL when a push makes lvl == DEPTH.
  - FULL->FILL on a pop with no push.
  - any->ALARM on a health failure.
  - ALARM->FILL on alarm_clr.
REQ-025 es_gen SHALL be 1 only in FILL. On leaving FILL, the partial word and flags SHALL be held, not discarded, and any filter output arriving while es_gen=0 SHALL still be collected; a word completing while lvl == DEPTH SHALL be dropped.
REQ-026 In ALARM: the FIFO SHALL be flushed (lvl=0, rdn_vld=0); the collector, slice counter and filters SHALL be cleared.
REQ-027 alarm_clr asserted in the same cycle as a new failure SHALL leave alarm=1 and the FSM in ALARM.
REQ-028 rdn SHALL be held stable while rdn_vld=1 and rdn_rdy=0.

Reset
REQ-029 On rst=1 the following SHALL be reset on the next edge:
  - es_gen=0, rdn_vld=0, rdn=0, lvl=0, alarm=0;
  - FSM=IDLE;
  - all filters, flags, counters and FIFO storage = 0.
REQ-030 rst mid-word or mid-burst SHALL discard all partial and buffered data.

Configuration
REQ-031 Macro TRNG_POOL_HEALTH_EN. When defined: each lane SHALL run a repetition-count test on raw es_rnb qualified by es_val; RCT_C identical consecutive raw bits SHALL set alarm and enter ALARM on the next edge.
REQ-032 When TRNG_POOL_HEALTH_EN is undefined: no health logic is built; alarm SHALL be constant 0; ALARM is unreachable; alarm_clr is ignored.

Structure
REQ-033 Package trng_pkg SHALL hold the FSM state enum and a clog2-based width helper constant for lvl.
REQ-034 One sub-module, trng_lane, SHALL implement the per-lane parity filter plus the optional repetition-count counter; it is instantiated RI times.

Verification
REQ-035 W=8, RI=4, O=1, all es_val=1, es_rnb=4'b1010 then 4'b0101 -> rdn=8'hA5, rdn_vld=1, lvl=1.
REQ-036 O=3, lane 0 bits 1,1,0 -> filtered bit 0. Bits 1,0,0 -> filtered bit 1, valid 1 cycle after the 3rd bit.
REQ-037 DEPTH=4, rdn_rdy=0, continuous entropy -> lvl reaches 4, es_gen=0, FSM=FULL. One pop -> lvl=3, es_gen=1 next cycle.
REQ-038 lvl=2, push and pop in the same cycle -> lvl stays 2 and rdn advances to the next word.
REQ-039 Health on, RCT_C=16, lane 2 holds 1 for 16 valid samples -> alarm=1, lvl=0, es_gen=0. alarm_clr pulse -> FILL, alarm=0.
REQ-040 rst asserted with lvl=3 and half a word collected -> next cycle lvl=0, rdn_vld=0; the first word after reset is built only from post-reset bits.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG entropy pool.
// Holds the control FSM state encoding and the width helper for the
// FIFO occupancy output.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam int DEFAULT_DEPTH = 4;

    // Occupancy needs one extra bit so that a completely full FIFO is representable.
    function automatic int lvlWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LVL_W = lvlWidth(DEFAULT_DEPTH);

endpackage

// File: rtl/trng_lane.sv
// One entropy lane: an order-O parity (XOR) filter over the qualified raw
// bits, plus an optional repetition-count health test on the raw stream.
// The health test is only built when TRNG_POOL_HEALTH_EN is defined.
module trng_lane #(
    parameter int O     = 3,
    parameter int RCT_C = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic rnb_i,
    input  logic val_i,
    output logic fbit_o,
    output logic fvld_o,
    output logic fail_o
);

    localparam int            CW   = (O > 1) ? $clog2(O) : 1;
    localparam logic [CW-1:0] LAST = CW'(O - 1);

    logic [CW-1:0] cnt_q;
    logic          acc_q;
    logic          fbit_q;
    logic          fvld_q;

    // Accumulate the XOR of accepted bits and emit it, registered, on every O-th one.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q  <= '0;
            acc_q  <= 1'b0;
            fbit_q <= 1'b0;
            fvld_q <= 1'b0;
        end else begin
            fvld_q <= 1'b0;
            if (val_i) begin
                if (cnt_q == LAST) begin
                    fbit_q <= acc_q ^ rnb_i;
                    fvld_q <= 1'b1;
                    acc_q  <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    acc_q  <= acc_q ^ rnb_i;
                    cnt_q  <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign fbit_o = fbit_q;
    assign fvld_o = fvld_q;

`ifdef TRNG_POOL_HEALTH_EN
    localparam logic [7:0] LIMIT = 8'(RCT_C - 1);

    logic [7:0] rep_q;
    logic       last_q;
    logic       seen_q;

    // A failure is flagged combinationally on the sample that completes a run of RCT_C,
    // and keeps firing while a stuck source continues, because the run length saturates.
    assign fail_o = val_i && seen_q && (rnb_i == last_q) && (rep_q >= LIMIT);

    // Track the current run length of identical raw bits; this ignores filter clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q  <= 8'd0;
            last_q <= 1'b0;
            seen_q <= 1'b0;
        end else if (val_i) begin
            last_q <= rnb_i;
            seen_q <= 1'b1;
            if (seen_q && (rnb_i == last_q)) begin
                rep_q <= (rep_q == 8'hFF) ? rep_q : rep_q + 8'd1;
            end else begin
                rep_q <= 8'd1;
            end
        end
    end
`else
    logic [7:0] unusedRct;
    assign unusedRct = 8'(RCT_C);
    assign fail_o    = 1'b0;
`endif

endmodule

// File: rtl/trng_pool.sv
// TRNG entropy pool: RI filtered lanes are gathered into W-bit words and
// buffered in a first-word-fall-through FIFO under a small control FSM.
// Define TRNG_POOL_HEALTH_EN to build the per-lane repetition-count test
// and the sticky alarm; without it, alarm is tied low and ALARM is unreachable.
module trng_pool
    import trng_pkg::*;
#(
    parameter int W     = 32,
    parameter int RI    = 8,
    parameter int O     = 3,
    parameter int DEPTH = 4,
    parameter int RCT_C = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         es_gen,
    input  logic [RI-1:0]                es_rnb,
    input  logic [RI-1:0]                es_val,
    output logic                         rdn_vld,
    input  logic                         rdn_rdy,
    output logic [W-1:0]                 rdn,
    output logic [lvlWidth(DEPTH)-1:0]   lvl,
    output logic                         alarm,
    input  logic                         alarm_clr
);

    localparam int             NS         = W / RI;
    localparam int             SCW        = (NS > 1) ? $clog2(NS) : 1;
    localparam int             AW         = $clog2(DEPTH);
    localparam int             LW         = lvlWidth(DEPTH);
    localparam logic [SCW-1:0] LAST_SLICE = SCW'(NS - 1);
    localparam logic [LW-1:0]  FULL_LVL   = LW'(DEPTH);
    localparam logic [LW-1:0]  ALMOST_LVL = LW'(DEPTH - 1);

    state_t state_q, state_d;

    logic [RI-1:0]  laneBit;
    logic [RI-1:0]  laneVld;
    logic [RI-1:0]  laneFail;
    logic           healthFail;
    logic           alarmClr;
    logic           flush;

    logic [RI-1:0]  flag_q, flag_d;
    logic [RI-1:0]  slice_q, slice_d;
    logic [W-1:0]   word_q, word_d;
    logic [SCW-1:0] sliceCnt_q, sliceCnt_d;
    logic           pushPend_q, pushPend_d;

    logic [W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [LW-1:0]  count_q;
    logic           push;
    logic           pop;

    assign flush = healthFail || (state_q == ALARM);

    for (genvar i = 0; i < RI; i++) begin : gLane
        trng_lane #(
            .O     (O),
            .RCT_C (RCT_C)
        ) uLane (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (flush),
            .rnb_i  (es_rnb[i]),
            .val_i  (es_val[i]),
            .fbit_o (laneBit[i]),
            .fvld_o (laneVld[i]),
            .fail_o (laneFail[i])
        );
    end

`ifdef TRNG_POOL_HEALTH_EN
    logic alarm_q;

    assign healthFail = |laneFail;
    assign alarmClr   = alarm_clr;
    assign alarm      = alarm_q;

    // Sticky alarm: a fresh failure wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else if (healthFail) begin
            alarm_q <= 1'b1;
        end else if (alarmClr) begin
            alarm_q <= 1'b0;
        end
    end
`else
    logic [RI:0] unusedHealth;
    assign unusedHealth = {alarm_clr, laneFail};
    assign healthFail   = 1'b0;
    assign alarmClr     = 1'b0;
    assign alarm        = 1'b0;
`endif

    // Collect one filtered bit per lane; once every lane has reported, shift the slice into the word.
    always_comb begin
        flag_d     = (&flag_q) ? '0 : flag_q;
        slice_d    = slice_q;
        word_d     = word_q;
        sliceCnt_d = sliceCnt_q;
        pushPend_d = 1'b0;
        for (int i = 0; i < RI; i++) begin
            if (laneVld[i]) begin
                flag_d[i]  = 1'b1;
                slice_d[i] = laneBit[i];
            end
        end
        if (&flag_q) begin
            word_d = (word_q << RI) | W'(slice_q);
            if (sliceCnt_q == LAST_SLICE) begin
                sliceCnt_d = '0;
                pushPend_d = 1'b1;
            end else begin
                sliceCnt_d = sliceCnt_q + 1'b1;
            end
        end
    end

    // Collector registers; an alarm throws away any partially built word.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            flag_q     <= '0;
            slice_q    <= '0;
            word_q     <= '0;
            sliceCnt_q <= '0;
            pushPend_q <= 1'b0;
        end else begin
            flag_q     <= flag_d;
            slice_q    <= slice_d;
            word_q     <= word_d;
            sliceCnt_q <= sliceCnt_d;
            pushPend_q <= pushPend_d;
        end
    end

    // A completed word arriving while the FIFO is full is simply dropped.
    assign push    = pushPend_q && (count_q != FULL_LVL) && !flush;
    assign pop     = rdn_vld && rdn_rdy;
    assign rdn_vld = (count_q != '0);
    assign rdn     = mem_q[rptr_q];
    assign lvl     = count_q;

    // FIFO storage and pointers; the head word is presented directly, so it cannot change without a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= word_q;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Control FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a health failure overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = FILL;
            FILL:  if (push && !pop && (count_q == ALMOST_LVL)) state_d = FULL;
            FULL:  if (pop && !push) state_d = FILL;
            ALARM: if (alarmClr) state_d = FILL;
            default: state_d = IDLE;
        endcase
        if (healthFail) begin
            state_d = ALARM;
        end
    end

    assign es_gen = (state_q == FILL);

endmodule

// File: tb/tb_trng_pool.sv
// Directed bench for trng_pool. Instance A (W=8, RI=4, O=1, DEPTH=4) covers
// word assembly, FIFO flow, full/refill, reset and the health alarm;
// instance B (O=3) covers the parity filter and its latency.
module tb_trng_pool;
    import trng_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic             esGenA, rdnVldA, rdnRdyA, alarmA, alarmClrA;
    logic [3:0]       esRnbA, esValA;
    logic [7:0]       rdnA;
    logic [LVL_W-1:0] lvlA;

    logic             esGenB, rdnVldB, rdnRdyB, alarmB, alarmClrB;
    logic [3:0]       esRnbB, esValB;
    logic [7:0]       rdnB;
    logic [LVL_W-1:0] lvlB;

    int nVectors     = 0;
    int nMiscompares = 0;

    always #5 clk = ~clk;

    trng_pool #(.W(8), .RI(4), .O(1), .DEPTH(4), .RCT_C(16)) dutA (
        .clk(clk), .rst(rst), .es_gen(esGenA), .es_rnb(esRnbA), .es_val(esValA),
        .rdn_vld(rdnVldA), .rdn_rdy(rdnRdyA), .rdn(rdnA), .lvl(lvlA),
        .alarm(alarmA), .alarm_clr(alarmClrA)
    );

    trng_pool #(.W(8), .RI(4), .O(3), .DEPTH(4), .RCT_C(16)) dutB (
        .clk(clk), .rst(rst), .es_gen(esGenB), .es_rnb(esRnbB), .es_val(esValB),
        .rdn_vld(rdnVldB), .rdn_rdy(rdnRdyB), .rdn(rdnB), .lvl(lvlB),
        .alarm(alarmB), .alarm_clr(alarmClrB)
    );

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one set of lane inputs on instance A for a single clock.
    task automatic applyStimulus(input logic [3:0] val, input logic [3:0] rnb);
        esValA = val;
        esRnbA = rnb;
        tick();
    endtask

    // Two slices on A, then idle long enough for the word to land in the FIFO.
    task automatic sendWordA(input logic [3:0] hi, input logic [3:0] lo);
        applyStimulus(4'hF, hi);
        applyStimulus(4'hF, lo);
        esValA = 4'h0;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] vecB [6];
        vecB[0] = 4'hB; vecB[1] = 4'h3; vecB[2] = 4'h6;
        vecB[3] = 4'h1; vecB[4] = 4'h0; vecB[5] = 4'h0;

        rst = 1'b1;
        esRnbA = '0; esValA = '0; rdnRdyA = 1'b0; alarmClrA = 1'b0;
        esRnbB = '0; esValB = '0; rdnRdyB = 1'b0; alarmClrB = 1'b0;
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rstLvl",   32'(lvlA),    32'd0);
        checkOutput("rstVld",   32'(rdnVldA), 32'd0);
        checkOutput("rstRdn",   32'(rdnA),    32'h00);
        checkOutput("rstGen",   32'(esGenA),  32'd0);
        checkOutput("rstAlarm", 32'(alarmA),  32'd0);

        rst = 1'b0;
        tick();
        checkOutput("fillGenA", 32'(esGenA), 32'd1);
        checkOutput("fillGenB", 32'(esGenB), 32'd1);

        $display("[TB] order-3 parity filter");
        for (int k = 0; k < 6; k++) begin
            esValB = 4'hF;
            esRnbB = vecB[k];
            tick();
        end
        esValB = 4'h0;
        tick();
        tick();
        checkOutput("filtLvlEarly", 32'(lvlB), 32'd0);
        tick();
        checkOutput("filtLvl", 32'(lvlB),    32'd1);
        checkOutput("filtVld", 32'(rdnVldB), 32'd1);
        checkOutput("filtRdn", 32'(rdnB),    32'hE1);

        $display("[TB] word assembly");
        applyStimulus(4'hF, 4'hA);
        applyStimulus(4'hF, 4'h5);
        esValA = 4'h0;
        tick();
        tick();
        checkOutput("asmLvlEarly", 32'(lvlA), 32'd0);
        tick();
        checkOutput("asmLvl", 32'(lvlA),    32'd1);
        checkOutput("asmVld", 32'(rdnVldA), 32'd1);
        checkOutput("asmRdn", 32'(rdnA),    32'hA5);

        $display("[TB] push and pop together");
        sendWordA(4'h3, 4'hC);
        checkOutput("twoLvl",  32'(lvlA), 32'd2);
        checkOutput("twoHead", 32'(rdnA), 32'hA5);
        applyStimulus(4'hF, 4'h7);
        applyStimulus(4'hF, 4'hE);
        esValA = 4'h0;
        tick();
        tick();
        rdnRdyA = 1'b1;
        tick();
        rdnRdyA = 1'b0;
        checkOutput("pushPopLvl", 32'(lvlA), 32'd2);
        checkOutput("pushPopRdn", 32'(rdnA), 32'h3C);
        rdnRdyA = 1'b1;
        tick();
        checkOutput("drainLvl1", 32'(lvlA), 32'd1);
        checkOutput("drainRdn1", 32'(rdnA), 32'h7E);
        tick();
        rdnRdyA = 1'b0;
        checkOutput("drainLvl0", 32'(lvlA),    32'd0);
        checkOutput("drainVld0", 32'(rdnVldA), 32'd0);

        $display("[TB] fill to full");
        for (int k = 0; k < 40 && lvlA != 3'd4; k++) begin
            applyStimulus(4'hF, 4'((k * 7 + 3) & 15));
        end
        esValA = 4'h0;
        checkOutput("fullLvl", 32'(lvlA),   32'd4);
        checkOutput("fullGen", 32'(esGenA), 32'd0);
        checkOutput("fullRdn", 32'(rdnA),   32'h3A);
        repeat (3) tick();
        checkOutput("holdLvl", 32'(lvlA),   32'd4);
        checkOutput("holdRdn", 32'(rdnA),   32'h3A);
        checkOutput("holdGen", 32'(esGenA), 32'd0);
        rdnRdyA = 1'b1;
        tick();
        rdnRdyA = 1'b0;
        checkOutput("refillLvl", 32'(lvlA),   32'd3);
        checkOutput("refillGen", 32'(esGenA), 32'd1);
        checkOutput("refillRdn", 32'(rdnA),   32'h18);

        $display("[TB] reset with buffered and partial data");
        rst = 1'b1;
        tick();
        checkOutput("midRstLvl", 32'(lvlA),    32'd0);
        checkOutput("midRstVld", 32'(rdnVldA), 32'd0);
        checkOutput("midRstRdn", 32'(rdnA),    32'h00);
        checkOutput("midRstGen", 32'(esGenA),  32'd0);
        rst = 1'b0;
        tick();
        sendWordA(4'hB, 4'h2);
        checkOutput("postRstLvl", 32'(lvlA), 32'd1);
        checkOutput("postRstRdn", 32'(rdnA), 32'hB2);

        $display("[TB] repetition count on lane 2");
        for (int k = 0; k < 15; k++) begin
            applyStimulus(4'hF, (k % 2 == 1) ? 4'hF : 4'h4);
        end
`ifdef TRNG_POOL_HEALTH_EN
        checkOutput("rctBelow", 32'(alarmA), 32'd0);
`endif
        applyStimulus(4'hF, 4'hF);
`ifdef TRNG_POOL_HEALTH_EN
        checkOutput("rctAlarm", 32'(alarmA),  32'd1);
        checkOutput("rctLvl",   32'(lvlA),    32'd0);
        checkOutput("rctVld",   32'(rdnVldA), 32'd0);
        checkOutput("rctGen",   32'(esGenA),  32'd0);
        alarmClrA = 1'b1;
        applyStimulus(4'hF, 4'h4);
        checkOutput("clrVsFailAlarm", 32'(alarmA), 32'd1);
        checkOutput("clrVsFailGen",   32'(esGenA), 32'd0);
        esValA = 4'h0;
        tick();
        alarmClrA = 1'b0;
        checkOutput("clrAlarm", 32'(alarmA), 32'd0);
        checkOutput("clrGen",   32'(esGenA), 32'd1);
        sendWordA(4'h9, 4'h6);
        checkOutput("afterClrLvl", 32'(lvlA), 32'd1);
        checkOutput("afterClrRdn", 32'(rdnA), 32'h96);
`else
        checkOutput("noHealthAlarm", 32'(alarmA), 32'd0);
        alarmClrA = 1'b1;
        esValA = 4'h0;
        tick();
        alarmClrA = 1'b0;
        checkOutput("noHealthAlarmClr", 32'(alarmA), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
